// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame layout and timing defaults.
// Reused by both the receive and the transmit side of the PS/2 port.
package ps2_pkg;

    // FSM state encoding (plain constants so legacy tools can consume them)
    typedef logic [1:0] ps2_state_t;
    localparam ps2_state_t ST_IDLE  = 2'd0;
    localparam ps2_state_t ST_SHIFT = 2'd1;
    localparam ps2_state_t ST_LOAD  = 2'd2;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Defaults sized for a 50 MHz system clock
    localparam int FILTER_LEN_DEF     = 8;
    localparam int TIMEOUT_CYCLES_DEF = 10000;

    // The ten bits that follow the start bit, in the order they land in the
    // shift register (first received bit ends up in bit 0).
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    // PS/2 uses odd parity: the nine bits together must hold an odd number of ones.
    function automatic logic parity_bad(input logic [7:0] data, input logic parity);
        return ~(^{data, parity});
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Bundle of the PS/2 receiver's line inputs, result outputs and debug taps.
//
// Handshake: rx_done is a one-cycle valid strobe with no backpressure. dout,
// parity_err and frame_err are qualified by rx_done, and they also hold their
// values until the next rx_done. rx_timeout is an independent one-cycle strobe.
// rx_idle is a level that is high while the receiver waits for a start bit.
interface ps2_rx_frame_if;
    import ps2_pkg::*;

    logic       ps2_c;
    logic       ps2_d;
    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       rx_timeout;
    logic       rx_idle;
    ps2_state_t dbg_state;
    logic [3:0] dbg_bit_cnt;

    // Receiver side
    modport slave (
        input  ps2_c, ps2_d, rx_en,
        output dout, rx_done, parity_err, frame_err, rx_timeout, rx_idle,
        output dbg_state, dbg_bit_cnt
    );

    // Line driver / consumer side
    modport master (
        output ps2_c, ps2_d, rx_en,
        input  dout, rx_done, parity_err, frame_err, rx_timeout, rx_idle,
        input  dbg_state, dbg_bit_cnt
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Front end for the PS/2 lines: 2-flop synchronizers on clock and data, a
// glitch filter on the clock, and a one-cycle pulse on each filtered falling
// edge. The synchronized data bit is presented so it can be sampled in the
// fall_edge cycle.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_c,
    input  logic ps2_d,
    output logic fall_edge,
    output logic data
);

    localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             c_meta;
    logic             c_sync;
    logic             d_meta;
    logic             d_sync;
    logic             filt;
    logic [CNT_W-1:0] run_cnt;
    logic             fall_q;

    // Two-stage synchronizers; reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= ps2_c;
            c_sync <= c_meta;
            d_meta <= ps2_d;
            d_sync <= d_meta;
        end
    end

    // Filtered level flips after FILTER_LEN consecutive samples disagree with it;
    // any agreeing sample restarts the run, so short pulses never get through.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt    <= 1'b1;
            run_cnt <= '0;
            fall_q  <= 1'b0;
        end else if (c_sync != filt) begin
            if (run_cnt == CNT_LAST) begin
                filt    <= c_sync;
                run_cnt <= '0;
                fall_q  <= filt;          // only a 1 -> 0 flip is a falling edge
            end else begin
                run_cnt <= run_cnt + 1'b1;
                fall_q  <= 1'b0;
            end
        end else begin
            run_cnt <= '0;
            fall_q  <= 1'b0;
        end
    end

    assign fall_edge = fall_q;
    assign data      = d_sync;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: collects start, 8 data bits (LSB first), odd parity and
// stop on filtered clock falling edges, reports the byte with error flags, and
// abandons a stalled frame through a watchdog.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    ps2_rx_frame_if.slave   bus
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES);
    // Watchdog fires on the (TIMEOUT_CYCLES-1)th quiet cycle so that the
    // registered rx_timeout shows up TIMEOUT_CYCLES cycles after the last edge.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 2);
    // Counter value when the stop bit (last of the ten post-start bits) arrives
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 2);

    logic             fall_edge;
    logic             data_s;
    ps2_state_t       state;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    ps2_frame_t       frame_next;
    logic [WD_W-1:0]  wd_cnt;
    logic [7:0]       dout_q;
    logic             perr_q;
    logic             ferr_q;
    logic             timeout_q;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_c     (bus.ps2_c),
        .ps2_d     (bus.ps2_d),
        .fall_edge (fall_edge),
        .data      (data_s)
    );

    // Shift register contents including the bit being sampled this cycle
    always_comb begin
        frame_next = ps2_frame_t'({data_s, shreg[9:1]});
    end

    // Receive FSM, watchdog and result registers. The results are written on
    // the stop-bit edge so they are already valid throughout the LOAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            wd_cnt    <= '0;
            dout_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fall_edge && bus.rx_en && !data_s) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        wd_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!bus.rx_en) begin
                        // transmitter took the line: drop the frame silently
                        state <= ST_IDLE;
                    end else if (fall_edge) begin
                        shreg   <= frame_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        wd_cnt  <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            dout_q <= frame_next.data;
                            perr_q <= parity_bad(frame_next.data, frame_next.parity);
                            ferr_q <= ~frame_next.stop;
                            state  <= ST_LOAD;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dout        = dout_q;
    assign bus.rx_done     = (state == ST_LOAD);
    assign bus.parity_err  = perr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.rx_timeout  = timeout_q;
    assign bus.rx_idle     = (state == ST_IDLE);
    assign bus.dbg_state   = state;
    assign bus.dbg_bit_cnt = bit_cnt;

endmodule
